// File: rtl/locked_adder_pkg.sv
// locked_adder_pkg: shared widths, unlock constant and scheduler state encoding
package locked_adder_pkg;
    localparam int DATA_W = 16;
    localparam int KEY_W = 32;
    localparam logic [KEY_W-1:0] LOCK_KEY = 32'h7641831B;
    typedef enum logic [2:0] {S_LOCKED, S_IDLE, S_ISSUE, S_EVAL, S_RESP} state_t;
endpackage

// File: rtl/key_loader.sv
// key_loader: serial shadow key register with saturating bit counter
module key_loader
    import locked_adder_pkg::*;
#(
    parameter int KEY_W = locked_adder_pkg::KEY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic             clear_i,
    output logic [KEY_W-1:0] shadow_key_o,
    output logic             full_o
);
    localparam int CW = $clog2(KEY_W + 1);
    localparam logic [CW-1:0] FULL = CW'(KEY_W);
    logic [KEY_W-1:0] r_shadow;
    logic [CW-1:0]    r_cnt;
    // a commit clears the count and swallows any shift in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (shift_i) begin
            r_shadow <= {r_shadow[KEY_W-2:0], bit_i};
            r_cnt    <= (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
        end
    end
    assign shadow_key_o = r_shadow;
    assign full_o = r_cnt == FULL;
endmodule

// File: rtl/locked_adder_core.sv
// locked_adder_core: key-gated parallel-prefix adder, exact sum only under the unlock key
module locked_adder_core
    import locked_adder_pkg::*;
#(
    parameter int DATA_W = locked_adder_pkg::DATA_W,
    parameter int KEY_W = locked_adder_pkg::KEY_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [DATA_W:0]   sum_o
);
    logic [KEY_W-1:0]  w_diff;
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_g;
    logic [DATA_W-1:0] w_c;
    // key bits that differ from the unlock key flip propagate/generate terms
    assign w_diff = key_i ^ KEY_W'(LOCK_KEY);
    assign w_p = (a_i ^ b_i) ^ w_diff[DATA_W-1:0];
    assign w_g = (a_i & b_i) ^ w_diff[2*DATA_W-1:DATA_W];
    // Kogge-Stone prefix tree; w_c[i] is the carry out of bit i
    always_comb begin : prefix
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] p;
        g = w_g;
        p = w_p;
        for (int d = 1; d < DATA_W; d = d * 2) begin
            g = g | (p & (g << d));
            p = p & ((p << d) | DATA_W'((1 << d) - 1));
        end
        w_c = g;
    end
    assign sum_o = {w_c[DATA_W-1], w_p ^ {w_c[DATA_W-2:0], 1'b0}};
endmodule

// File: rtl/locked_adder_scheduler.sv
// locked_adder_scheduler: round-robin two-requester front end sequencing the key-locked adder
module locked_adder_scheduler
    import locked_adder_pkg::*;
#(
    parameter int DATA_W = locked_adder_pkg::DATA_W,
    parameter int KEY_W = locked_adder_pkg::KEY_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_bit_i,
    input  logic              key_shift_i,
    input  logic              key_commit_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W:0]   rsp_sum_o,
    output logic              locked_o,
    output logic              key_err_o
);
    state_t            r_state;
    state_t            w_next;
    logic [KEY_W-1:0]  r_key;
    logic [KEY_W-1:0]  w_shadow;
    logic              w_full;
    logic              w_commit_ok;
    logic              w_hs;
    logic              r_rr;
    logic              r_id;
    logic              r_key_err;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W:0]   r_sum;
    logic [DATA_W:0]   w_sum;

    key_loader #(.KEY_W(KEY_W)) u_key_loader (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .shift_i      (key_shift_i),
        .bit_i        (key_bit_i),
        .clear_i      (key_commit_i),
        .shadow_key_o (w_shadow),
        .full_o       (w_full)
    );

    locked_adder_core #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_core (
        .a_i   (r_a),
        .b_i   (r_b),
        .key_i (r_key),
        .sum_o (w_sum)
    );

    assign w_commit_ok = key_commit_i & w_full & (r_state == S_LOCKED || r_state == S_IDLE);
    assign req0_ready_o = (r_state == S_IDLE) & req0_valid_i & (~req1_valid_i | ~r_rr);
    assign req1_ready_o = (r_state == S_IDLE) & req1_valid_i & (~req0_valid_i | r_rr);
    assign w_hs = req0_ready_o | req1_ready_o;

    // next-state: unlock, grant, two pipeline steps, then hold until the result is taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOCKED: w_next = w_commit_ok ? S_IDLE : S_LOCKED;
            S_IDLE:   w_next = w_hs ? S_ISSUE : S_IDLE;
            S_ISSUE:  w_next = S_EVAL;
            S_EVAL:   w_next = S_RESP;
            S_RESP:   w_next = rsp_ready_i ? S_IDLE : S_RESP;
            default:  w_next = S_LOCKED;
        endcase
    end

    // state register; reset re-locks and drops any in-flight request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_LOCKED;
        else r_state <= w_next;
    end

    // key, operand capture, arbitration pointer and result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_key     <= '0;
            r_key_err <= 1'b0;
            r_rr      <= 1'b0;
            r_id      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
        end else begin
            r_key_err <= key_commit_i & ~w_commit_ok;
            if (w_commit_ok) r_key <= w_shadow;
            if (w_hs) begin
                r_a  <= req1_ready_o ? req1_a_i : req0_a_i;
                r_b  <= req1_ready_o ? req1_b_i : req0_b_i;
                r_id <= req1_ready_o;
                if (req0_valid_i & req1_valid_i) r_rr <= ~r_rr;
            end
            if (r_state == S_ISSUE) r_sum <= w_sum;
        end
    end

    assign rsp_valid_o = r_state == S_RESP;
    assign rsp_sum_o = r_sum;
    assign rsp_id_o = r_id;
    assign locked_o = r_state == S_LOCKED;
    assign key_err_o = r_key_err;
endmodule

// File: tb/tb_locked_adder_scheduler.sv
// tb_locked_adder_scheduler: directed vector bench for the locked adder scheduler
module tb_locked_adder_scheduler;
    localparam logic [31:0] KEY = 32'h7641831B;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_bit = 1'b0;
    logic        key_shift = 1'b0;
    logic        key_commit = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] b0 = '0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        rsp_ready = 1'b0;
    logic        r0;
    logic        r1;
    logic        rsp_valid;
    logic        rsp_id;
    logic [16:0] rsp_sum;
    logic        locked;
    logic        key_err;

    vec_t vecs [7];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    locked_adder_scheduler dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .key_bit_i    (key_bit),
        .key_shift_i  (key_shift),
        .key_commit_i (key_commit),
        .req0_valid_i (v0),
        .req0_ready_o (r0),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req1_valid_i (v1),
        .req1_ready_o (r1),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_sum_o    (rsp_sum),
        .locked_o     (locked),
        .key_err_o    (key_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        key_shift = 1'b0;
        key_commit = 1'b0;
        rsp_ready = 1'b0;
        v0 = 1'b1;
        v1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_locked", locked, 1);
        check("rst_readies", {r0, r1}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_key_err", key_err, 0);
        v0 = 1'b0;
        v1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic shift_key(input logic [31:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            key_bit = k[31-i];
            key_shift = 1'b1;
            @(negedge clk);
        end
        key_shift = 1'b0;
    endtask

    task automatic commit(input logic exp_err, input logic exp_locked);
        key_commit = 1'b1;
        @(negedge clk);
        key_commit = 1'b0;
        check("commit_err", key_err, exp_err);
        check("commit_locked", locked, exp_locked);
        @(negedge clk);
        check("err_pulse_len", key_err, 0);
    endtask

    task automatic txn(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] sum, input string tag);
        int n = 0;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else begin v0 = 1'b1; a0 = a; b0 = b; end
        #1;
        while (!(id ? r1 : r0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("%s_grant", tag), id ? r1 : r0, 1);
        check($sformatf("%s_other_ready", tag), id ? r0 : r1, 0);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        check($sformatf("%s_valid_t1", tag), rsp_valid, 0);
        @(negedge clk);
        check($sformatf("%s_valid_t2", tag), rsp_valid, 0);
        @(negedge clk);
        check($sformatf("%s_valid_t3", tag), rsp_valid, 1);
        check($sformatf("%s_sum", tag), rsp_sum, sum);
        check($sformatf("%s_id", tag), rsp_id, id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("%s_valid_after", tag), rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic        exp_id [3];
        logic [16:0] exp_sum [3];
        int          got;
        int          n;
        int          seen;
        vecs[0] = '{1'b0, 16'h29AF, 16'h7A1B, 17'h0A3CA};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 17'h00000};
        vecs[3] = '{1'b1, 16'h8000, 16'h8000, 17'h10000};
        vecs[4] = '{1'b0, 16'h1234, 16'h4321, 17'h05555};
        vecs[5] = '{1'b1, 16'h0001, 16'hFFFF, 17'h10000};
        vecs[6] = '{1'b0, 16'h5555, 16'hAAAA, 17'h0FFFF};
        exp_id = '{1'b0, 1'b1, 1'b0};
        exp_sum = '{17'h18942, 17'h0FFFF, 17'h18942};

        // full key unlocks, then the vector table
        apply_reset();
        shift_key(KEY, 32);
        commit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));

        // commit with a simultaneous shift uses the pre-shift shadow; the count is then cleared
        shift_key(KEY, 32);
        key_shift = 1'b1;
        key_bit = 1'b1;
        key_commit = 1'b1;
        @(negedge clk);
        key_shift = 1'b0;
        key_commit = 1'b0;
        check("shift_commit_err", key_err, 0);
        txn(1'b0, 16'h29AF, 16'h7A1B, 17'h0A3CA, "post_shift_commit");
        commit(1'b1, 1'b0);

        // short key is rejected and a request stalls until a proper unlock
        apply_reset();
        shift_key(KEY, 31);
        commit(1'b1, 1'b1);
        v0 = 1'b1;
        a0 = 16'h29AF;
        b0 = 16'h7A1B;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("stall_ready", r0, 0);
            check("stall_locked", locked, 1);
        end
        shift_key(KEY, 32);
        key_commit = 1'b1;
        @(negedge clk);
        key_commit = 1'b0;
        #1;
        check("unstall_locked", locked, 0);
        check("unstall_ready", r0, 1);
        @(negedge clk);
        v0 = 1'b0;
        repeat (2) @(negedge clk);
        check("unstall_valid", rsp_valid, 1);
        check("unstall_sum", rsp_sum, 17'h0A3CA);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // both requesters valid: grants alternate, then backpressure on the result
        apply_reset();
        shift_key(KEY, 32);
        commit(1'b0, 1'b0);
        a0 = 16'h8943; b0 = 16'hFFFF; a1 = 16'h5555; b1 = 16'hAAAA;
        v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check($sformatf("rr_id%0d", got), rsp_id, exp_id[got]);
                check($sformatf("rr_sum%0d", got), rsp_sum, exp_sum[got]);
                got++;
            end
        end
        check("rr_count", got, 3);
        @(negedge clk);
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", rsp_valid, 1);
        check("bp_id", rsp_id, 1);
        check("bp_sum", rsp_sum, 17'h0FFFF);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_id", rsp_id, 1);
            check("bp_hold_sum", rsp_sum, 17'h0FFFF);
            check("bp_hold_readies", {r0, r1}, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_released", rsp_valid, 0);
        check("bp_next_grant", {r0, r1}, 2'b10);
        v0 = 1'b0;
        v1 = 1'b0;

        // late commit is rejected, then reset during EVAL abandons the request
        apply_reset();
        shift_key(KEY, 32);
        commit(1'b0, 1'b0);
        v0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321;
        #1;
        check("mid_grant", r0, 1);
        @(negedge clk);
        v0 = 1'b0;
        key_commit = 1'b1;
        @(negedge clk);
        key_commit = 1'b0;
        check("busy_commit_err", key_err, 1);
        check("busy_locked", locked, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_locked", locked, 1);
        check("mid_rst_sum", rsp_sum, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_err", key_err, 0);
        check("mid_rst_ready", r0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid || r0) seen++;
        end
        check("post_rst_quiet", seen, 0);
        check("post_rst_locked", locked, 1);
        v0 = 1'b0;
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/locked_adder_scheduler.md
LOCKED_ADDER_SCHEDULER -- requirements
Module: locked_adder_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the operand width.
REQ-002 SHALL have parameter KEY_W, default 32, meaning the locking-key width.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port key_bit_i, input, 1 bit, serial key data.
REQ-006 SHALL have port key_shift_i, input, 1 bit, shift key_bit_i into the shadow key register.
REQ-007 SHALL have port key_commit_i, input, 1 bit, copy the shadow key into the active key.
REQ-008 SHALL have ports reqN_valid_i (input, 1 bit), reqN_ready_o (output, 1 bit), reqN_a_i (input, DATA_W bits) and reqN_b_i (input, DATA_W bits) for N = 0 and N = 1, forming the requester operand channels.
REQ-009 SHALL have ports rsp_valid_o (output, 1 bit), rsp_ready_i (input, 1 bit), rsp_id_o (output, 1 bit) and rsp_sum_o (output, DATA_W+1 bits), forming the result channel.
REQ-010 SHALL have port locked_o, output, 1 bit, high while no valid key has been committed.
REQ-011 SHALL have port key_err_o, output, 1 bit, one-cycle pulse flagging a rejected commit.

Function
REQ-012 SHALL sequence the team's key-locked 16-bit CLA adder core through an FSM with states LOCKED, IDLE, ISSUE, EVAL and RESP; the core has a 17-bit result and a 32-bit key.
REQ-013 SHALL, on key_shift_i, shift the shadow key MSB-first (shadow = {shadow[KEY_W-2:0], key_bit_i}) in any state; a 6-bit shift counter SHALL increment and saturate at KEY_W.
REQ-014 SHALL accept key_commit_i only in LOCKED or IDLE with shift count == KEY_W: active key <= shadow, shift counter <= 0, and LOCKED -> IDLE.
REQ-015 SHALL, on key_commit_i with shift count < KEY_W or in any other state, leave the active key unchanged, pulse key_err_o for one cycle and clear the shift counter.
REQ-016 SHALL, if key_shift_i and key_commit_i are high in the same cycle, apply the commit using the pre-shift shadow and count, and discard the shift.
REQ-017 SHALL drive reqN_ready_o low in every state except IDLE; in LOCKED, requests SHALL stall, not be dropped.
REQ-018 SHALL arbitrate in IDLE: a single valid requester is granted; when both are valid, the requester selected by the 1-bit round-robin pointer is granted and the pointer then points to the other requester.
REQ-019 SHALL have at most one reqN_ready_o high per cycle; the handshake completes on valid & ready.
REQ-020 SHALL, on handshake at cycle t, register operands and grant id (IDLE -> ISSUE at t+1), register the adder output (ISSUE -> EVAL at t+2), and assert rsp_valid_o with registered sum and id (EVAL -> RESP at t+3).
REQ-021 SHALL hold rsp_valid_o, rsp_sum_o and rsp_id_o stable in RESP until rsp_ready_i; RESP -> IDLE on acceptance, and a new grant is possible in the cycle after acceptance.
REQ-022 SHALL produce rsp_sum_o = {carry, sum} with no truncation; for example, FFFF + FFFF gives 17'h1FFFE.
REQ-023 SHALL make the active key constant during ISSUE, EVAL and RESP.
REQ-024 SHALL make locked_o high exactly in LOCKED.

Reset
REQ-025 SHALL, while rst_ni is low, force state LOCKED, shadow and active key to 0, shift counter to 0, round-robin pointer to 0, all readies low, rsp_valid_o low, rsp_sum_o 0, rsp_id_o 0, key_err_o low and locked_o high.
REQ-026 SHALL, on reset mid-operation, abandon any in-flight request with no response, and require the key to be reloaded.
REQ-027 SHALL release reset synchronously to clk_i; the first transition is possible on the first rising edge after deassertion.

Structure
REQ-028 SHALL place DATA_W, KEY_W and the FSM state enum in a shared package locked_adder_pkg.
REQ-029 SHALL implement the shadow register and shift counter as one sub-module, key_loader, which outputs shadow_key and full flag.
REQ-030 SHALL instantiate the adder core once, combinationally, between the operand and result registers.

Verification
REQ-031 SHALL cover: shift 32 bits of 32'h7641831B, then commit -> locked_o falls next cycle, key_err_o stays low.
REQ-032 SHALL cover: shift 31 bits, then commit -> key_err_o pulses 1 cycle, locked_o stays high, the later req0 stalls.
REQ-033 SHALL cover: correct key, req0 a=16'h29AF b=16'h7A1B accepted at t -> rsp_valid_o at t+3, rsp_sum_o=17'h0A3CA, rsp_id_o=0.
REQ-034 SHALL cover: both requesters valid continuously (req0 8943+FFFF, req1 5555+AAAA) -> grants alternate 0,1,0; sums 17'h18942 and 17'h0FFFF.
REQ-035 SHALL cover: rsp_ready_i held low 5 cycles -> rsp outputs stable and both readies low; accept -> new grant the next cycle.
REQ-036 SHALL cover: rst_ni pulsed low during EVAL -> rsp_valid_o never asserts, locked_o high, all outputs at reset values.
